difftest_commit_serializer: RTL and testbench



---
 rtl/difftest_commit_serializer_pkg.sv | 33 +++
 rtl/difftest_commit_serializer_if.sv | 59 +++++
 rtl/difftest_commit_fifo.sv | 69 ++++++
 rtl/difftest_commit_serializer.sv | 138 +++++++++++++
 tb/tb_difftest_commit_serializer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/difftest_commit_serializer_pkg.sv
// ============================================================================
// Module   : difftest_commit_serializer_pkg
// Purpose  : Shared difftest record field widths and the packed record layout
//            used by the capture stage, the commit serializer and the sink.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// Record field widths as plain defines so that non-package users (capture
// stage, trace sink) can size their ports from the same source.
`ifndef NCPU64K_CONFIG_DEFS
`define NCPU64K_CONFIG_DEFS
`define PC_W             32
`define NCPU_INSN_DW     32
`define NCPU_LRF_AW      5
`define NCPU_EXCP_VECT_W 8
`endif

package difftest_commit_serializer_pkg;

  localparam int PC_W        = `PC_W;
  localparam int INSN_DW     = `NCPU_INSN_DW;
  localparam int LRF_AW      = `NCPU_LRF_AW;
  localparam int EXCP_VECT_W = `NCPU_EXCP_VECT_W;

  // Packed record layout, MSB first: {excp, excp_vect, wen, wnum, wdata, insn, pc}
  function automatic int rec_width(input int dw);
    return 1 + EXCP_VECT_W + 1 + LRF_AW + dw + INSN_DW + PC_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/difftest_commit_serializer_if.sv
// ============================================================================
// Module   : difftest_commit_serializer_if
// Purpose  : Commit-side multi-lane input bundle plus the single-lane
//            valid/ready trace output and status flags.
//            master = commit stage / sink side, slave = serializer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface difftest_commit_serializer_if #(
  parameter int CW = 1,
  parameter int DW = 64
);
  import difftest_commit_serializer_pkg::*;

  // commit side, CW lanes
  logic [CW-1:0]          i_valid;
  logic [PC_W*CW-1:0]     i_pc;
  logic [INSN_DW*CW-1:0]  i_insn;
  logic [CW-1:0]          i_wen;
  logic [LRF_AW*CW-1:0]   i_wnum;
  logic [DW*CW-1:0]       i_wdata;
  logic                   i_excp;
  logic [EXCP_VECT_W-1:0] i_excp_vect;

  // trace side, single lane
  logic                   o_valid;
  logic                   o_ready;
  logic [PC_W-1:0]        o_pc;
  logic [INSN_DW-1:0]     o_insn;
  logic                   o_wen;
  logic [LRF_AW-1:0]      o_wnum;
  logic [DW-1:0]          o_wdata;
  logic                   o_excp;
  logic [EXCP_VECT_W-1:0] o_excp_vect;
  logic [31:0]            o_seq;

  // status
  logic                   stall_req;
  logic                   overflow;
  logic [15:0]            drop_cnt;

  modport master (
    output i_valid, i_pc, i_insn, i_wen, i_wnum, i_wdata, i_excp, i_excp_vect,
    output o_ready,
    input  o_valid, o_pc, o_insn, o_wen, o_wnum, o_wdata, o_excp, o_excp_vect, o_seq,
    input  stall_req, overflow, drop_cnt
  );

  modport slave (
    input  i_valid, i_pc, i_insn, i_wen, i_wnum, i_wdata, i_excp, i_excp_vect,
    input  o_ready,
    output o_valid, o_pc, o_insn, o_wen, o_wnum, o_wdata, o_excp, o_excp_vect, o_seq,
    output stall_req, overflow, drop_cnt
  );

endinterface

`default_nettype wire

// File: rtl/difftest_commit_fifo.sv
// ============================================================================
// Module   : difftest_commit_fifo
// Purpose  : Multi-push (up to NPUSH per cycle), single-pop FIFO with an
//            occupancy output. The caller guarantees a push never exceeds
//            the free space; a pop is only issued when occupancy is nonzero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module difftest_commit_fifo #(
  parameter int W     = 8,
  parameter int NPUSH = 2,
  parameter int AW    = 3,
  parameter int CNT_W = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CNT_W-1:0]           push_cnt,
  input  logic [NPUSH-1:0][W-1:0]    push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [AW:0]                occ
);

  localparam int DEPTH = 1 << AW;

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW-1:0]           wptr_q, wptr_d;
  logic [AW-1:0]           rptr_q, rptr_d;
  logic [AW:0]             occ_q, occ_d;
  logic [AW-1:0]           waddr;

  // Scatter the first push_cnt records into consecutive slots; advance pointers.
  always_comb begin
    mem_d = mem_q;
    waddr = wptr_q;
    for (int k = 0; k < NPUSH; k++) begin
      waddr = wptr_q + AW'(k);
      if (CNT_W'(k) < push_cnt) mem_d[waddr] = push_data[k];
    end
    wptr_d = wptr_q + AW'(push_cnt);
    rptr_d = rptr_q + AW'(pop);
    occ_d  = occ_q + (AW+1)'(push_cnt) - (AW+1)'(pop);
  end

  // Storage carries no reset: emptiness is defined by occupancy alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointer and occupancy state; reset empties the FIFO immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  assign head = mem_q[rptr_q];
  assign occ  = occ_q;

endmodule

`default_nettype wire

// File: rtl/difftest_commit_serializer.sv
// ============================================================================
// Module   : difftest_commit_serializer
// Purpose  : Packs up to CW commit lanes (plus a standalone exception record)
//            per cycle into a FIFO and emits one record per cycle over a
//            valid/ready port. Whole groups that do not fit are dropped and
//            counted; stall_req warns the commit stage one cycle ahead.
// Config   : NCPU_DIFFTEST_SEQ_EN - builds the 32-bit o_seq counter;
//            when undefined o_seq is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module difftest_commit_serializer
  import difftest_commit_serializer_pkg::*;
#(
  parameter int CONFIG_DW             = 64,
  parameter int CONFIG_P_COMMIT_WIDTH = 0,
  parameter int CONFIG_P_FIFO_DEPTH   = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  difftest_commit_serializer_if.slave  bus
);

  localparam int CW    = 1 << CONFIG_P_COMMIT_WIDTH;
  localparam int NPUSH = CW + 1;
  localparam int AW    = CONFIG_P_FIFO_DEPTH;
  localparam int DEPTH = 1 << AW;
  localparam int CNT_W = $clog2(NPUSH + 1);
  localparam int IDX_W = $clog2(NPUSH);
  localparam int REC_W = rec_width(CONFIG_DW);

  logic [NPUSH-1:0][REC_W-1:0] slots;
  logic [CNT_W-1:0]            push_cnt;
  logic                        lane_excp;
  logic [REC_W-1:0]            head;
  logic [AW:0]                 occ, occ_next, free_now, free_next, push_ext;
  logic                        accept, drop, pop;
  logic                        stall_req_q, stall_req_d;
  logic                        overflow_q, overflow_d;
  logic [15:0]                 drop_cnt_q, drop_cnt_d;

  // Pack valid lanes in ascending order; a lone exception goes first.
  always_comb begin
    slots     = '0;
    push_cnt  = '0;
    lane_excp = 1'b0;
    if (bus.i_excp && !bus.i_valid[0]) begin
      slots[0] = {1'b1, bus.i_excp_vect, 1'b0, {LRF_AW{1'b0}},
                  {CONFIG_DW{1'b0}}, {INSN_DW{1'b0}}, {PC_W{1'b0}}};
      push_cnt = CNT_W'(1);
    end
    for (int i = 0; i < CW; i++) begin
      if (bus.i_valid[i]) begin
        lane_excp = (i == 0) && bus.i_excp;
        slots[IDX_W'(push_cnt)] = {lane_excp,
                                   lane_excp ? bus.i_excp_vect : {EXCP_VECT_W{1'b0}},
                                   bus.i_wen[i],
                                   bus.i_wnum[i*LRF_AW +: LRF_AW],
                                   bus.i_wdata[i*CONFIG_DW +: CONFIG_DW],
                                   bus.i_insn[i*INSN_DW +: INSN_DW],
                                   bus.i_pc[i*PC_W +: PC_W]};
        push_cnt = push_cnt + CNT_W'(1);
      end
    end
  end

  // All-or-nothing admission against free space at the start of the cycle.
  always_comb begin
    push_ext    = (AW+1)'(push_cnt);
    free_now    = (AW+1)'(DEPTH) - occ;
    accept      = (push_cnt != '0) && (free_now >= push_ext);
    drop        = (push_cnt != '0) && (free_now < push_ext);
    pop         = bus.o_valid && bus.o_ready;
    occ_next    = occ + (accept ? push_ext : '0) - (AW+1)'(pop);
    free_next   = (AW+1)'(DEPTH) - occ_next;
    stall_req_d = free_next < (AW+1)'(NPUSH);
    overflow_d  = overflow_q | drop;
    drop_cnt_d  = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end

  // Status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_req_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      stall_req_q <= stall_req_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  difftest_commit_fifo #(
    .W     (REC_W),
    .NPUSH (NPUSH),
    .AW    (AW),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_cnt  (accept ? push_cnt : '0),
    .push_data (slots),
    .pop       (pop),
    .head      (head),
    .occ       (occ)
  );

  assign bus.o_valid = (occ != '0);
  assign {bus.o_excp, bus.o_excp_vect, bus.o_wen, bus.o_wnum,
          bus.o_wdata, bus.o_insn, bus.o_pc} = head;
  assign bus.stall_req = stall_req_q;
  assign bus.overflow  = overflow_q;
  assign bus.drop_cnt  = drop_cnt_q;

`ifdef NCPU_DIFFTEST_SEQ_EN
  logic [31:0] seq_q, seq_d;

  // Next sequence number: advances once per popped record, wrapping naturally.
  always_comb begin
    seq_d = pop ? seq_q + 32'd1 : seq_q;
  end

  // Sequence counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seq_q <= '0;
    else        seq_q <= seq_d;
  end

  assign bus.o_seq = seq_q;
`else
  assign bus.o_seq = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_difftest_commit_serializer.sv
// ============================================================================
// Module   : tb_difftest_commit_serializer
// Purpose  : Directed self-checking bench, CW=2, DW=32, DEPTH=8.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_difftest_commit_serializer;

  localparam int CW = 2;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   exp_seq = 0;

  always #5 clk = ~clk;

  difftest_commit_serializer_if #(.CW(CW), .DW(DW)) bus ();

  difftest_commit_serializer #(
    .CONFIG_DW             (DW),
    .CONFIG_P_COMMIT_WIDTH (1),
    .CONFIG_P_FIFO_DEPTH   (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] seq_exp();
`ifdef NCPU_DIFFTEST_SEQ_EN
    return 32'(exp_seq);
`else
    return 32'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.i_valid = '0; bus.i_pc = '0; bus.i_insn = '0; bus.i_wen = '0;
    bus.i_wnum = '0; bus.i_wdata = '0; bus.i_excp = 1'b0; bus.i_excp_vect = '0;
  endtask

  // Lane record derived from pc: insn = pc^0x13000000, wnum = pc[4:0], wdata = {pc[15:0],BEEF}
  task automatic set_lane(input int l, input logic [31:0] pc);
    bus.i_valid[l] = 1'b1;
    bus.i_pc[l*32 +: 32] = pc;
    bus.i_insn[l*32 +: 32] = pc ^ 32'h1300_0000;
    bus.i_wen[l] = 1'b1;
    bus.i_wnum[l*5 +: 5] = pc[4:0];
    bus.i_wdata[l*32 +: 32] = {pc[15:0], 16'hBEEF};
  endtask

  task automatic test_reset();
    idle_in();
    bus.o_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", bus.o_valid); end
    tests++; if (bus.stall_req !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", bus.stall_req); end
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
    tests++; if (bus.drop_cnt !== 16'd0) begin fails++; $display("FAIL reset_drop_cnt got %0d want 0", bus.drop_cnt); end
    tests++; if (bus.o_seq !== 32'd0) begin fails++; $display("FAIL reset_seq got %0d want 0", bus.o_seq); end
    #10;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bus.o_ready = 1'b1;
    idle_in();
    set_lane(0, 32'h100);
    set_lane(1, 32'h101);
    #1;
    tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL basic_same_cycle got %b want 0", bus.o_valid); end
    tick();
    idle_in();
    tests++; if (bus.o_valid !== 1'b1) begin fails++; $display("FAIL basic_valid0 got %b want 1", bus.o_valid); end
    tests++; if (bus.o_pc !== 32'h100) begin fails++; $display("FAIL basic_pc0 got %h want 100", bus.o_pc); end
    tests++; if (bus.o_insn !== 32'h1300_0100) begin fails++; $display("FAIL basic_insn0 got %h want 13000100", bus.o_insn); end
    tests++; if (bus.o_seq !== seq_exp()) begin fails++; $display("FAIL basic_seq0 got %0d want %0d", bus.o_seq, seq_exp()); end
    exp_seq++;
    tick();
    tests++; if (bus.o_valid !== 1'b1) begin fails++; $display("FAIL basic_valid1 got %b want 1", bus.o_valid); end
    tests++; if (bus.o_pc !== 32'h101) begin fails++; $display("FAIL basic_pc1 got %h want 101", bus.o_pc); end
    tests++; if (bus.o_wnum !== 5'd1 || bus.o_wen !== 1'b1) begin fails++; $display("FAIL basic_wnum1 got %0d/%b want 1/1", bus.o_wnum, bus.o_wen); end
    tests++; if (bus.o_wdata !== 32'h0101_BEEF) begin fails++; $display("FAIL basic_wdata1 got %h want 0101beef", bus.o_wdata); end
    tests++; if (bus.o_seq !== seq_exp()) begin fails++; $display("FAIL basic_seq1 got %0d want %0d", bus.o_seq, seq_exp()); end
    exp_seq++;
    tick();
    tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL basic_drained got %b want 0", bus.o_valid); end
  endtask

  task automatic test_excp();
    bus.o_ready = 1'b1;
    idle_in();
    bus.i_excp = 1'b1;
    bus.i_excp_vect = 8'h18;
    set_lane(1, 32'h200);
    tick();
    idle_in();
    tests++; if (bus.o_valid !== 1'b1 || bus.o_excp !== 1'b1) begin fails++; $display("FAIL excp_alone got v=%b e=%b want 1/1", bus.o_valid, bus.o_excp); end
    tests++; if (bus.o_excp_vect !== 8'h18) begin fails++; $display("FAIL excp_alone_vect got %h want 18", bus.o_excp_vect); end
    tests++; if (bus.o_pc !== 32'h0 || bus.o_insn !== 32'h0 || bus.o_wen !== 1'b0) begin fails++; $display("FAIL excp_alone_fields got pc=%h insn=%h wen=%b want 0/0/0", bus.o_pc, bus.o_insn, bus.o_wen); end
    exp_seq++;
    tick();
    tests++; if (bus.o_pc !== 32'h200 || bus.o_excp !== 1'b0) begin fails++; $display("FAIL excp_lane1 got pc=%h e=%b want 200/0", bus.o_pc, bus.o_excp); end
    tests++; if (bus.o_seq !== seq_exp()) begin fails++; $display("FAIL excp_lane1_seq got %0d want %0d", bus.o_seq, seq_exp()); end
    // exception attached to lane 0, pushed while the lane-1 record pops
    bus.i_excp = 1'b1;
    bus.i_excp_vect = 8'h20;
    set_lane(0, 32'h300);
    exp_seq++;
    tick();
    idle_in();
    tests++; if (bus.o_pc !== 32'h300 || bus.o_excp !== 1'b1) begin fails++; $display("FAIL excp_attach got pc=%h e=%b want 300/1", bus.o_pc, bus.o_excp); end
    tests++; if (bus.o_excp_vect !== 8'h20) begin fails++; $display("FAIL excp_attach_vect got %h want 20", bus.o_excp_vect); end
    exp_seq++;
    tick();
    tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL excp_attach_single got %b want 0", bus.o_valid); end
  endtask

  task automatic test_overflow();
    logic [31:0] want_pc;
    bus.o_ready = 1'b0;
    for (int g = 0; g < 4; g++) begin
      idle_in();
      set_lane(0, 32'h400 + 32'(2*g));
      set_lane(1, 32'h401 + 32'(2*g));
      tick();
      tests++; if (bus.stall_req !== (g >= 2)) begin fails++; $display("FAIL ovf_stall_g%0d got %b want %b", g, bus.stall_req, (g >= 2)); end
    end
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL ovf_before got %b want 0", bus.overflow); end
    idle_in();
    set_lane(0, 32'h408);
    set_lane(1, 32'h409);
    tick();
    tests++; if (bus.overflow !== 1'b1 || bus.drop_cnt !== 16'd1) begin fails++; $display("FAIL ovf_drop1 got ovf=%b cnt=%0d want 1/1", bus.overflow, bus.drop_cnt); end
    tests++; if (bus.o_pc !== 32'h400 || bus.stall_req !== 1'b1) begin fails++; $display("FAIL ovf_head got pc=%h stall=%b want 400/1", bus.o_pc, bus.stall_req); end
    // push against a full FIFO while popping: pop wins, push dropped
    bus.o_ready = 1'b1;
    idle_in();
    set_lane(0, 32'h500);
    set_lane(1, 32'h501);
    exp_seq++;
    tick();
    idle_in();
    tests++; if (bus.drop_cnt !== 16'd2) begin fails++; $display("FAIL ovf_full_pop_drop got %0d want 2", bus.drop_cnt); end
    for (int k = 1; k < 8; k++) begin
      want_pc = 32'h400 + 32'(k);
      tests++; if (bus.o_valid !== 1'b1 || bus.o_pc !== want_pc) begin fails++; $display("FAIL ovf_drain%0d got v=%b pc=%h want 1/%h", k, bus.o_valid, bus.o_pc, want_pc); end
      tests++; if (bus.o_seq !== seq_exp()) begin fails++; $display("FAIL ovf_drain_seq%0d got %0d want %0d", k, bus.o_seq, seq_exp()); end
      exp_seq++;
      tick();
    end
    tests++; if (bus.o_valid !== 1'b0 || bus.stall_req !== 1'b0) begin fails++; $display("FAIL ovf_empty got v=%b stall=%b want 0/0", bus.o_valid, bus.stall_req); end
    tests++; if (bus.overflow !== 1'b1 || bus.drop_cnt !== 16'd2) begin fails++; $display("FAIL ovf_sticky got ovf=%b cnt=%0d want 1/2", bus.overflow, bus.drop_cnt); end
  endtask

  task automatic test_ready_toggle();
    bus.o_ready = 1'b0;
    idle_in();
    set_lane(0, 32'h600);
    set_lane(1, 32'h601);
    tick();
    idle_in();
    set_lane(0, 32'h602);
    tick();
    idle_in();
    bus.o_ready = 1'b1;
    tests++; if (bus.o_pc !== 32'h600 || bus.o_seq !== seq_exp()) begin fails++; $display("FAIL rdy_first got pc=%h seq=%0d want 600/%0d", bus.o_pc, bus.o_seq, seq_exp()); end
    exp_seq++;
    tick();
    tests++; if (bus.o_pc !== 32'h601 || bus.o_seq !== seq_exp()) begin fails++; $display("FAIL rdy_second got pc=%h seq=%0d want 601/%0d", bus.o_pc, bus.o_seq, seq_exp()); end
    bus.o_ready = 1'b0;
    tick();
    tests++; if (bus.o_valid !== 1'b1 || bus.o_pc !== 32'h601 || bus.o_seq !== seq_exp()) begin fails++; $display("FAIL rdy_hold got v=%b pc=%h seq=%0d want 1/601/%0d", bus.o_valid, bus.o_pc, bus.o_seq, seq_exp()); end
    bus.o_ready = 1'b1;
    exp_seq++;
    tick();
    tests++; if (bus.o_pc !== 32'h602 || bus.o_seq !== seq_exp()) begin fails++; $display("FAIL rdy_third got pc=%h seq=%0d want 602/%0d", bus.o_pc, bus.o_seq, seq_exp()); end
    exp_seq++;
    tick();
    tests++; if (bus.o_valid !== 1'b0 || bus.o_seq !== seq_exp()) begin fails++; $display("FAIL rdy_done got v=%b seq=%0d want 0/%0d", bus.o_valid, bus.o_seq, seq_exp()); end
  endtask

  task automatic test_async_reset();
    bus.o_ready = 1'b0;
    idle_in(); set_lane(0, 32'h700); set_lane(1, 32'h701); tick();
    idle_in(); set_lane(0, 32'h702); set_lane(1, 32'h703); tick();
    idle_in(); set_lane(0, 32'h704); tick();
    idle_in();
    tests++; if (bus.o_valid !== 1'b1) begin fails++; $display("FAIL arst_pre got %b want 1", bus.o_valid); end
    #2;
    rst_n = 1'b0;
    exp_seq = 0;
    #1;
    tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL arst_valid got %b want 0", bus.o_valid); end
    tests++; if (bus.overflow !== 1'b0 || bus.drop_cnt !== 16'd0 || bus.o_seq !== 32'd0) begin fails++; $display("FAIL arst_status got ovf=%b cnt=%0d seq=%0d want 0/0/0", bus.overflow, bus.drop_cnt, bus.o_seq); end
    #2;
    rst_n = 1'b1;
    tick();
    bus.o_ready = 1'b1;
    set_lane(0, 32'h7A0);
    tick();
    idle_in();
    tests++; if (bus.o_valid !== 1'b1 || bus.o_pc !== 32'h7A0 || bus.o_seq !== 32'd0) begin fails++; $display("FAIL arst_after got v=%b pc=%h seq=%0d want 1/7a0/0", bus.o_valid, bus.o_pc, bus.o_seq); end
    exp_seq++;
    tick();
    tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL arst_single got %b want 0", bus.o_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_excp();
    test_overflow();
    test_ready_toggle();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
